// File: rtl/thunderbird_light_fsm.sv
// ThunderBird tail-light sequencer: synchronizes turn/hazard switches and steps
// the six-lamp pattern once per TICK_DIV clocks.
module thunderbird_light_fsm #(
   parameter  int TICK_DIV = 12_500_000,
   localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left,
   input  logic       right,
   input  logic       hazard,
   output logic [5:0] light_pattern,
   output logic       active
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      L2   = 3'd2,
      L3   = 3'd3,
      R1   = 3'd4,
      R2   = 3'd5,
      R3   = 3'd6,
      LR3  = 3'd7
   } state_t;

   state_t           state, nxt;
   logic [1:0]       l_q, r_q, h_q;
   logic             l_s, r_s, h_s;
   logic [CNT_W-1:0] cnt;
   logic             tick;

   assign l_s  = l_q[1];
   assign r_s  = r_q[1];
   assign h_s  = h_q[1];
   assign tick = (cnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_q <= '0;
         r_q <= '0;
         h_q <= '0;
         cnt <= '0;
      end else begin
         l_q <= {l_q[0], left};
         r_q <= {r_q[0], right};
         h_q <= {h_q[0], hazard};
         cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
   end

   function automatic logic [5:0] pattern(input state_t s);
      case (s)
         L1:      pattern = 6'b001000;
         L2:      pattern = 6'b011000;
         L3:      pattern = 6'b111000;
         R1:      pattern = 6'b000100;
         R2:      pattern = 6'b000110;
         R3:      pattern = 6'b000111;
         LR3:     pattern = 6'b111111;
         default: pattern = 6'b000000;
      endcase
   endfunction

   // Once a turn sequence starts it always runs to L3/R3; only hazard can cut it short.
   always_comb begin
      nxt = state;
      if (tick) begin
         case (state)
            IDLE: begin
               if (h_s || (l_s && r_s)) nxt = LR3;
               else if (l_s)            nxt = L1;
               else if (r_s)            nxt = R1;
               else                     nxt = IDLE;
            end
            L1:      nxt = h_s ? LR3 : L2;
            L2:      nxt = h_s ? LR3 : L3;
            R1:      nxt = h_s ? LR3 : R2;
            R2:      nxt = h_s ? LR3 : R3;
            L3, R3:  nxt = IDLE;
            LR3:     nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   // Outputs decode the next state so they move on the same edge as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         light_pattern <= 6'b000000;
         active        <= 1'b0;
      end else begin
         state         <= nxt;
         light_pattern <= pattern(nxt);
         active        <= (nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_thunderbird_light_fsm.sv
// Bench for thunderbird_light_fsm: directed scenarios plus random input runs,
// compared every clock against a mode/step reference model.
module tb_thunderbird_light_fsm;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       left = 1'b0, right = 1'b0, hazard = 1'b0;
   logic [5:0] light_pattern;
   logic       active;

   int checks = 0;
   int fails  = 0;

   // Reference model: mode 0=none 1=left 2=right 3=hazard, step 1..3 within a turn.
   int         m_mode, m_step, m_cnt;
   logic [1:0] m_l, m_r, m_h;

   thunderbird_light_fsm #(.TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst), .left(left), .right(right), .hazard(hazard),
      .light_pattern(light_pattern), .active(active)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] exp_pat();
      logic [5:0] p;
      case (m_mode)
         1:       p = 6'(((1 << m_step) - 1) << 3);
         2:       p = 6'((7 << (3 - m_step)) & 7);
         3:       p = 6'h3F;
         default: p = 6'h00;
      endcase
      return p;
   endfunction

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_clear();
      m_mode = 0; m_step = 0; m_cnt = 0;
      m_l = '0; m_r = '0; m_h = '0;
   endtask

   // Drive inputs, take one edge, advance the model, then compare 1 ns later.
   task automatic step(input logic l, input logic r, input logic h, input string tag);
      logic tk, ls, rs, hs;
      left = l; right = r; hazard = h;
      @(posedge clk);
      tk = (m_cnt == TD - 1);
      ls = m_l[1]; rs = m_r[1]; hs = m_h[1];
      if (tk) begin
         if (m_mode == 0) begin
            if (hs || (ls && rs)) m_mode = 3;
            else if (ls) begin m_mode = 1; m_step = 1; end
            else if (rs) begin m_mode = 2; m_step = 1; end
         end else if (m_mode == 3) begin
            m_mode = 0;
         end else if (m_step == 3) begin
            m_mode = 0; m_step = 0;
         end else if (hs) begin
            m_mode = 3; m_step = 0;
         end else begin
            m_step++;
         end
      end
      m_cnt = tk ? 0 : m_cnt + 1;
      m_l = {m_l[0], l}; m_r = {m_r[0], r}; m_h = {m_h[0], h};
      #1;
      check({tag, ".pat"}, light_pattern, exp_pat());
      check({tag, ".act"}, {5'b0, active}, {5'b0, 1'(m_mode != 0)});
   endtask

   // Async reset between edges: outputs must clear before the next clock edge.
   task automatic do_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      check({tag, ".rst_pat"}, light_pattern, 6'h00);
      check({tag, ".rst_act"}, {5'b0, active}, 6'h00);
      model_clear();
      left = 1'b0; right = 1'b0; hazard = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
   endtask

   initial begin
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("por.pat", light_pattern, 6'h00);
      check("por.act", {5'b0, active}, 6'h00);
      #2 rst = 1'b0;

      // Left held from release: L1..L3, IDLE, then repeats.
      for (int i = 0; i < 24; i++) step(1, 0, 0, "left");

      // Reset landing in L2.
      do_reset("pre_l2");
      for (int i = 0; i < 9; i++) step(1, 0, 0, "to_l2");
      check("in_l2", light_pattern, 6'b011000);
      do_reset("mid_l2");
      for (int i = 0; i < 8; i++) step(0, 0, 0, "post_rst");

      // Right pulse for 6 clocks, sequence must still complete.
      do_reset("r");
      for (int i = 0; i < 6; i++)  step(0, 1, 0, "right_on");
      for (int i = 0; i < 20; i++) step(0, 0, 0, "right_off");

      // Hazard preempts a left sequence before L2.
      do_reset("hz");
      for (int i = 0; i < 4; i++)  step(1, 0, 0, "hz_l1");
      check("hz_in_l1", light_pattern, 6'b001000);
      for (int i = 0; i < 2; i++)  step(1, 0, 1, "hz_both");
      for (int i = 0; i < 2; i++)  step(0, 0, 1, "hz_on");
      check("hz_preempt", light_pattern, 6'h3F);
      for (int i = 0; i < 16; i++) step(0, 0, 1, "hz_blink");

      // Left and right together behave as hazard.
      do_reset("lr");
      for (int i = 0; i < 16; i++) step(1, 1, 0, "lr");

      // One-clock glitch that never lines up with a tick.
      do_reset("gl");
      step(0, 0, 0, "gl0");
      step(0, 0, 0, "gl1");
      step(1, 0, 0, "gl2");
      for (int i = 0; i < 12; i++) step(0, 0, 0, "gl_idle");
      check("gl_quiet", light_pattern, 6'h00);

      // Random held input patterns with occasional resets.
      do_reset("rnd");
      for (int s = 0; s < 80; s++) begin
         logic rl, rr, rh;
         int   len;
         rl  = ($urandom_range(0, 2) == 0);
         rr  = ($urandom_range(0, 2) == 0);
         rh  = ($urandom_range(0, 5) == 0);
         len = $urandom_range(1, 10);
         for (int k = 0; k < len; k++) step(rl, rr, rh, "rnd");
         if ($urandom_range(0, 19) == 0) do_reset("rnd_rst");
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
